k_pulse_cycle_monitor: RTL and testbench

- Downstream consumer of the Idle/Start/Stop/Clear controller's K2 (Stop->Clear) and K1 (Clear->Idle) pulses.
- A full controller cycle is a K2 followed later by a K1. The block counts completed cycles and measures the K2-to-K1 interval in Clock cycles.
- Flags out-of-order pulses and timeouts.
- Presents each measurement to a register/CPU stage through a Valid/Ack handshake.

---
 rtl/k_pulse_cycle_monitor_if.sv | 28 ++
 rtl/k_pulse_cycle_monitor.sv | 100 ++++++++++
 tb/tb_k_pulse_cycle_monitor.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/k_pulse_cycle_monitor_if.sv
// Bundle between the K-pulse cycle monitor and its controller/CPU-side users.
// slave = monitor side, master = driver of pulses, Ack and Clr.
interface k_pulse_cycle_monitor_if #(
    parameter int CNT_W = 8,
    parameter int DUR_W = 12
);
    logic             K2;
    logic             K1;
    logic             Ack;
    logic             Clr;
    logic [CNT_W-1:0] Cycles;
    logic [DUR_W-1:0] Dur;
    logic             Valid;
    logic             Busy;
    logic             Err;
    logic             Overrun;
    logic             Timeout;

    modport master (
        output K2, K1, Ack, Clr,
        input  Cycles, Dur, Valid, Busy, Err, Overrun, Timeout
    );

    modport slave (
        input  K2, K1, Ack, Clr,
        output Cycles, Dur, Valid, Busy, Err, Overrun, Timeout
    );
endinterface

// File: rtl/k_pulse_cycle_monitor.sv
// Measures K2->K1 intervals of the Idle/Start/Stop/Clear controller, counts
// completed cycles and hands each interval to a Valid/Ack consumer.
module k_pulse_cycle_monitor #(
    parameter int CNT_W = 8,
    parameter int DUR_W = 12
) (
    input logic                      Clock,
    input logic                      Reset,
    k_pulse_cycle_monitor_if.slave   bus
);
    localparam logic [0:0] WAIT_K2 = 1'b0;
    localparam logic [0:0] WAIT_K1 = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [DUR_W-1:0] dur_cnt, dur_cnt_nxt;
    logic             complete, err_set, to_set, ovr_set;

    logic [CNT_W-1:0] cycles_q;
    logic [DUR_W-1:0] dur_q;
    logic             valid_q, busy_q, err_q, ovr_q, to_q;

    // Simultaneous K1/K2 is a protocol error that freezes the measurement.
    always_comb begin
        state_nxt   = state;
        dur_cnt_nxt = dur_cnt;
        complete    = 1'b0;
        err_set     = 1'b0;
        to_set      = 1'b0;
        if (bus.K1 && bus.K2) begin
            err_set = 1'b1;
        end else begin
            case (state)
                WAIT_K2: begin
                    if (bus.K2) begin
                        state_nxt   = WAIT_K1;
                        dur_cnt_nxt = DUR_W'(1);
                    end else if (bus.K1) begin
                        err_set = 1'b1;
                    end
                end
                default: begin
                    if (bus.K1) begin
                        complete  = 1'b1;
                        state_nxt = WAIT_K2;
                    end else if (bus.K2) begin
                        err_set     = 1'b1;
                        dur_cnt_nxt = DUR_W'(1);
                    end else if (&dur_cnt) begin
                        to_set    = 1'b1;
                        state_nxt = WAIT_K2;
                    end else begin
                        dur_cnt_nxt = dur_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign ovr_set = complete & valid_q & ~bus.Ack;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= WAIT_K2;
            dur_cnt  <= '0;
            cycles_q <= '0;
            dur_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state   <= state_nxt;
            dur_cnt <= dur_cnt_nxt;
            busy_q  <= (state_nxt == WAIT_K1);
            // Sticky flags: a same-cycle event beats Clr.
            err_q   <= err_set | (err_q & ~bus.Clr);
            ovr_q   <= ovr_set | (ovr_q & ~bus.Clr);
            to_q    <= to_set  | (to_q  & ~bus.Clr);
            if (complete) begin
                dur_q   <= dur_cnt;
                valid_q <= 1'b1;
            end else if (bus.Ack) begin
                valid_q <= 1'b0;
            end
            if (bus.Clr)
                cycles_q <= complete ? CNT_W'(1) : '0;
            else if (complete && !(&cycles_q))
                cycles_q <= cycles_q + 1'b1;
        end
    end

    assign bus.Cycles  = cycles_q;
    assign bus.Dur     = dur_q;
    assign bus.Valid   = valid_q;
    assign bus.Busy    = busy_q;
    assign bus.Err     = err_q;
    assign bus.Overrun = ovr_q;
    assign bus.Timeout = to_q;
endmodule

// File: tb/tb_k_pulse_cycle_monitor.sv
// Directed vector bench for k_pulse_cycle_monitor with narrow counters so
// saturation and timeout are reachable in a short run.
module tb_k_pulse_cycle_monitor;
    localparam int CNT_W = 2;
    localparam int DUR_W = 4;

    logic Clock = 1'b0;
    logic Reset;

    k_pulse_cycle_monitor_if #(.CNT_W(CNT_W), .DUR_W(DUR_W)) bus ();

    k_pulse_cycle_monitor #(.CNT_W(CNT_W), .DUR_W(DUR_W)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic             rst, k2, k1, ack, clr;
        logic [CNT_W-1:0] cyc;
        logic [DUR_W-1:0] dur;
        logic             vld, busy, err, ovr, to;
    } vec_t;

    vec_t tv[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic void addn(int n, logic rst, logic k2, logic k1, logic ack, logic clr,
                                 logic [CNT_W-1:0] cyc, logic [DUR_W-1:0] dur,
                                 logic vld, logic busy, logic err, logic ovr, logic to);
        vec_t v;
        v.rst = rst; v.k2 = k2; v.k1 = k1; v.ack = ack; v.clr = clr;
        v.cyc = cyc; v.dur = dur; v.vld = vld; v.busy = busy;
        v.err = err; v.ovr = ovr; v.to = to;
        for (int i = 0; i < n; i++) tv.push_back(v);
    endfunction

    task automatic drive(logic rst, logic k2, logic k1, logic ack, logic clr);
        Reset   = rst;
        bus.K2  = k2;
        bus.K1  = k1;
        bus.Ack = ack;
        bus.Clr = clr;
    endtask

    task automatic check(string name, logic [CNT_W-1:0] cyc, logic [DUR_W-1:0] dur,
                         logic vld, logic busy, logic err, logic ovr, logic to);
        logic [CNT_W+DUR_W+4:0] act, exp;
        act = {bus.Cycles, bus.Dur, bus.Valid, bus.Busy, bus.Err, bus.Overrun, bus.Timeout};
        exp = {cyc, dur, vld, busy, err, ovr, to};
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got cyc=%0d dur=%0d vld=%b busy=%b err=%b ovr=%b to=%b, want cyc=%0d dur=%0d vld=%b busy=%b err=%b ovr=%b to=%b",
                     name, bus.Cycles, bus.Dur, bus.Valid, bus.Busy, bus.Err, bus.Overrun,
                     bus.Timeout, cyc, dur, vld, busy, err, ovr, to);
        end
    endtask

    initial begin
        //       n   rst k2 k1 ack clr  cyc dur vld busy err ovr to
        addn(2,  1,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);   // reset
        addn(1,  0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        addn(1,  0,  1, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0);   // K2
        addn(4,  0,  0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0);
        addn(1,  0,  0, 1, 0, 0,   1, 5, 1, 0, 0, 0, 0);   // K1 -> Dur 5
        addn(1,  0,  0, 0, 0, 0,   1, 5, 1, 0, 0, 0, 0);
        addn(1,  0,  0, 0, 1, 0,   1, 5, 0, 0, 0, 0, 0);   // Ack
        addn(1,  0,  0, 0, 1, 0,   1, 5, 0, 0, 0, 0, 0);   // Ack while idle
        addn(1,  0,  0, 1, 0, 0,   1, 5, 0, 0, 1, 0, 0);   // stray K1
        addn(1,  0,  0, 0, 0, 1,   0, 5, 0, 0, 0, 0, 0);   // Clr
        addn(1,  0,  1, 0, 0, 0,   0, 5, 0, 1, 0, 0, 0);
        addn(1,  0,  1, 1, 0, 0,   0, 5, 0, 1, 1, 0, 0);   // K1&K2: frozen
        addn(1,  0,  0, 0, 0, 0,   0, 5, 0, 1, 1, 0, 0);
        addn(1,  0,  0, 1, 0, 0,   1, 2, 1, 0, 1, 0, 0);   // Dur 2
        addn(1,  0,  0, 0, 0, 1,   0, 2, 1, 0, 0, 0, 0);   // Clr keeps Valid
        addn(1,  0,  1, 0, 0, 0,   0, 2, 1, 1, 0, 0, 0);   // timeout run
        addn(14, 0,  0, 0, 0, 0,   0, 2, 1, 1, 0, 0, 0);
        addn(1,  0,  0, 0, 0, 0,   0, 2, 1, 0, 0, 0, 1);   // saturated
        addn(1,  0,  0, 1, 0, 0,   0, 2, 1, 0, 1, 0, 1);   // late K1
        addn(1,  0,  0, 0, 1, 1,   0, 2, 0, 0, 0, 0, 0);
        addn(1,  0,  1, 0, 0, 0,   0, 2, 0, 1, 0, 0, 0);   // interval 3
        addn(2,  0,  0, 0, 0, 0,   0, 2, 0, 1, 0, 0, 0);
        addn(1,  0,  0, 1, 0, 0,   1, 3, 1, 0, 0, 0, 0);
        addn(1,  0,  1, 0, 0, 0,   1, 3, 1, 1, 0, 0, 0);   // interval 7
        addn(6,  0,  0, 0, 0, 0,   1, 3, 1, 1, 0, 0, 0);
        addn(1,  0,  0, 1, 0, 0,   2, 7, 1, 0, 0, 1, 0);   // overrun
        addn(1,  0,  0, 0, 1, 1,   0, 7, 0, 0, 0, 0, 0);
        addn(1,  0,  1, 0, 0, 0,   0, 7, 0, 1, 0, 0, 0);
        addn(2,  0,  0, 0, 0, 0,   0, 7, 0, 1, 0, 0, 0);
        addn(1,  0,  0, 1, 0, 0,   1, 3, 1, 0, 0, 0, 0);
        addn(1,  0,  1, 0, 0, 0,   1, 3, 1, 1, 0, 0, 0);
        addn(6,  0,  0, 0, 0, 0,   1, 3, 1, 1, 0, 0, 0);
        addn(1,  0,  0, 1, 1, 0,   2, 7, 1, 0, 0, 0, 0);   // Ack + completion
        addn(1,  0,  0, 0, 1, 1,   0, 7, 0, 0, 0, 0, 0);
        addn(1,  0,  1, 0, 0, 0,   0, 7, 0, 1, 0, 0, 0);   // saturation
        addn(1,  0,  0, 1, 1, 0,   1, 1, 1, 0, 0, 0, 0);
        addn(1,  0,  1, 0, 0, 0,   1, 1, 1, 1, 0, 0, 0);
        addn(1,  0,  0, 1, 1, 0,   2, 1, 1, 0, 0, 0, 0);
        addn(1,  0,  1, 0, 0, 0,   2, 1, 1, 1, 0, 0, 0);
        addn(1,  0,  0, 1, 1, 0,   3, 1, 1, 0, 0, 0, 0);
        addn(1,  0,  1, 0, 0, 0,   3, 1, 1, 1, 0, 0, 0);
        addn(1,  0,  0, 1, 1, 0,   3, 1, 1, 0, 0, 0, 0);   // holds at 3
        addn(1,  0,  1, 0, 0, 0,   3, 1, 1, 1, 0, 0, 0);
        addn(1,  0,  0, 1, 1, 1,   1, 1, 1, 0, 0, 0, 0);   // Clr + completion
        addn(1,  0,  1, 0, 0, 0,   1, 1, 1, 1, 0, 0, 0);
        addn(1,  0,  0, 0, 0, 0,   1, 1, 1, 1, 0, 0, 0);
        addn(1,  1,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);   // reset mid-measure
        addn(1,  0,  0, 1, 0, 0,   0, 0, 0, 0, 1, 0, 0);   // K1 after reset
        addn(1,  0,  0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0);
        addn(1,  0,  0, 1, 0, 1,   0, 0, 0, 0, 1, 0, 0);   // flag beats Clr
        addn(1,  0,  0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0);

        drive(1, 0, 0, 0, 0);
        foreach (tv[i]) begin
            drive(tv[i].rst, tv[i].k2, tv[i].k1, tv[i].ack, tv[i].clr);
            @(posedge Clock);
            #1;
            check($sformatf("vec%0d", i), tv[i].cyc, tv[i].dur, tv[i].vld,
                  tv[i].busy, tv[i].err, tv[i].ovr, tv[i].to);
        end

        // Longest legal interval: K1 on the 15th edge after K2 is a completion.
        drive(0, 1, 0, 0, 0);
        @(posedge Clock); #1;
        check("max_k2", 0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            @(posedge Clock); #1;
            check($sformatf("max_wait%0d", i), 0, 0, 0, 1, 0, 0, 0);
        end
        drive(0, 0, 1, 0, 0);
        @(posedge Clock); #1;
        check("max_k1", 1, 15, 1, 0, 0, 0, 0);

        // K2 while waiting restarts the measurement and flags Err.
        drive(0, 1, 0, 1, 1);
        @(posedge Clock); #1;
        check("rs_k2", 0, 15, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        repeat (3) @(posedge Clock);
        #1;
        drive(0, 1, 0, 0, 0);
        @(posedge Clock); #1;
        check("rs_restart", 0, 15, 0, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        @(posedge Clock); #1;
        drive(0, 0, 1, 0, 0);
        @(posedge Clock); #1;
        check("rs_dur", 1, 2, 1, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
